// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmd_pkg
// Description : Opcodes, state encodings and argument-count helper shared by
//               the serial command engine and its reply serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_cmd_pkg;

    localparam logic [7:0] OP_VERSION = 8'h00;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_TOGGLE  = 8'h03;
    localparam logic [7:0] OP_HIST    = 8'h0A;

    // Command-level states; ENG_TX covers the whole reply (TX_SEND/TX_GAP
    // live inside the serialiser).
    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_ARGS = 2'd1,
        ENG_EXEC = 2'd2,
        ENG_TX   = 2'd3
    } eng_state_t;

    // Reply serialiser states.
    typedef enum logic [1:0] {
        TXS_IDLE = 2'd0,
        TXS_SEND = 2'd1,
        TXS_GAP  = 2'd2
    } tx_state_t;

    // Number of argument bytes that follow a given opcode.
    function automatic logic [1:0] nargs(input logic [7:0] opcode);
        case (opcode)
            OP_WRITE, OP_TOGGLE: nargs = 2'd2;
            OP_READ:             nargs = 2'd1;
            default:             nargs = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_cmd_engine_byte_tx_seq.sv
`default_nettype none
// ============================================================================
// Module      : byte_tx_seq
// Description : Serialises a reply buffer, byte 0 first, onto a UART
//               transmitter using a tx_start / tx_busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_tx_seq
    import serial_cmd_pkg::*;
#(
    parameter int NBYTES = 136,
    parameter int IDXW   = $clog2(NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [IDXW-1:0]       len_i,
    input  logic [NBYTES*8-1:0]   buf_i,
    input  logic                  tx_busy_i,
    output logic                  tx_start_o,
    output logic [7:0]            tx_data_o,
    output logic                  done_o
);

    tx_state_t         state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   len_q, len_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        w_bytes [NBYTES];
    logic [7:0]        w_cur;
    logic [IDXW-1:0]   w_idx_inc;

    for (genvar b = 0; b < NBYTES; b++) begin : g_bytes
        assign w_bytes[b] = buf_i[8*b +: 8];
    end

    assign w_idx_inc = idx_q + IDXW'(1);

    // Byte currently addressed by the index (compare-based mux, no wrap).
    always_comb begin
        w_cur = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDXW'(b)) begin
                w_cur = w_bytes[b];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TXS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: wait for a free transmitter, then force one idle gap cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TXS_IDLE: if (start_i)    state_d = TXS_SEND;
            TXS_SEND: if (!tx_busy_i) state_d = TXS_GAP;
            TXS_GAP:  state_d = (w_idx_inc >= len_q) ? TXS_IDLE : TXS_SEND;
            default:  state_d = TXS_IDLE;
        endcase
    end

    // Outputs and datapath: tx_start is a registered one-cycle strobe.
    always_comb begin
        idx_d      = idx_q;
        len_d      = len_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        done_o     = 1'b0;
        case (state_q)
            TXS_IDLE: begin
                if (start_i) begin
                    idx_d = '0;
                    len_d = len_i;
                end
            end
            TXS_SEND: begin
                if (!tx_busy_i) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = w_cur;
                end
            end
            TXS_GAP: begin
                idx_d = w_idx_inc;
                if (w_idx_inc >= len_q) begin
                    done_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            len_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            idx_q      <= idx_d;
            len_q      <= len_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

endmodule
`default_nettype wire

// File: rtl/serial_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : serial_cmd_engine
// Description : UART host-command decoder driving an indexed bank of 8-bit
//               configuration registers, with read-back, bit toggles,
//               histogram snapshot/dump and an argument timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cmd_engine
    import serial_cmd_pkg::*;
#(
    parameter logic [7:0]          VERSION  = 8'd24,
    parameter int                  NREG     = 16,
    parameter logic [NREG*8-1:0]   CFG_INIT = '0,
    parameter int                  NBINS    = 34,
    parameter int                  BIN_W    = 32,
    parameter int                  TIMEOUT  = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    output logic [NREG*8-1:0]         cfg,
    output logic [NREG-1:0]           cfg_update,
    input  logic [NBINS*BIN_W-1:0]    hist_data,
    output logic                      hist_reset,
    output logic                      busy
);

    localparam int              c_NBYTES  = NBINS * BIN_W / 8;
    localparam int              c_IDXW    = $clog2(c_NBYTES + 1);
    localparam int              c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(TIMEOUT);

    eng_state_t                 state_q, state_d;
    logic [7:0]                 opcode_q, opcode_d;
    logic [7:0]                 arg0_q, arg0_d;
    logic [7:0]                 arg1_q, arg1_d;
    logic                       argcnt_q, argcnt_d;
    logic [c_TW-1:0]            tmo_q, tmo_d;
    logic [7:0]                 cfg_q [NREG];
    logic [7:0]                 cfg_d [NREG];
    logic [NREG-1:0]            upd_q, upd_d;
    logic                       hist_reset_q, hist_reset_d;
    logic [NBINS*BIN_W-1:0]     shadow_q, shadow_d;
    logic [7:0]                 reply_q, reply_d;
    logic                       w_start;
    logic                       w_done;
    logic [c_IDXW-1:0]          w_len;
    logic [c_NBYTES*8-1:0]      w_buf;
    logic [7:0]                 w_rd_byte;

    // Read-back mux; out-of-range addresses read as zero.
    always_comb begin
        w_rd_byte = 8'h00;
        for (int k = 0; k < NREG; k++) begin
            if (arg0_q == 8'(k)) begin
                w_rd_byte = cfg_q[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: opcode, optional arguments (with timeout), execute, reply.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ENG_IDLE: begin
                if (rx_ready) begin
                    state_d = (nargs(rx_data) == 2'd0) ? ENG_EXEC : ENG_ARGS;
                end
            end
            ENG_ARGS: begin
                if (rx_ready) begin
                    if ({1'b0, argcnt_q} + 2'd1 == nargs(opcode_q)) begin
                        state_d = ENG_EXEC;
                    end
                end else if (tmo_q == c_TMO_MAX) begin
                    state_d = ENG_IDLE;
                end
            end
            ENG_EXEC: state_d = w_start ? ENG_TX : ENG_IDLE;
            ENG_TX:   if (w_done) state_d = ENG_IDLE;
            default:  state_d = ENG_IDLE;
        endcase
    end

    // Outputs and datapath: byte capture, command actions, reply launch.
    always_comb begin
        opcode_d     = opcode_q;
        arg0_d       = arg0_q;
        arg1_d       = arg1_q;
        argcnt_d     = argcnt_q;
        cfg_d        = cfg_q;
        upd_d        = '0;
        hist_reset_d = 1'b0;
        shadow_d     = shadow_q;
        reply_d      = reply_q;
        w_start      = 1'b0;
        w_len        = '0;
        // Counter restarts on every received byte and saturates otherwise.
        if (rx_ready) begin
            tmo_d = '0;
        end else if (tmo_q == c_TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + c_TW'(1);
        end
        case (state_q)
            ENG_IDLE: begin
                if (rx_ready) begin
                    opcode_d = rx_data;
                    argcnt_d = 1'b0;
                end
            end
            ENG_ARGS: begin
                if (rx_ready) begin
                    if (!argcnt_q) begin
                        arg0_d = rx_data;
                    end else begin
                        arg1_d = rx_data;
                    end
                    argcnt_d = 1'b1;
                end
            end
            ENG_EXEC: begin
                case (opcode_q)
                    OP_VERSION: begin
                        reply_d = VERSION;
                        w_start = 1'b1;
                        w_len   = c_IDXW'(1);
                    end
                    OP_WRITE: begin
                        for (int k = 0; k < NREG; k++) begin
                            if (arg0_q == 8'(k)) begin
                                cfg_d[k] = arg1_q;
                                upd_d[k] = 1'b1;
                            end
                        end
                    end
                    OP_READ: begin
                        reply_d = w_rd_byte;
                        w_start = 1'b1;
                        w_len   = c_IDXW'(1);
                    end
                    OP_TOGGLE: begin
                        for (int k = 0; k < NREG; k++) begin
                            if (arg0_q == 8'(k)) begin
                                cfg_d[k][arg1_q[2:0]] = ~cfg_q[k][arg1_q[2:0]];
                                upd_d[k] = 1'b1;
                            end
                        end
                    end
                    OP_HIST: begin
                        shadow_d     = hist_data;
                        hist_reset_d = 1'b1;
                        w_start      = 1'b1;
                        w_len        = c_IDXW'(c_NBYTES);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q     <= 8'h00;
            arg0_q       <= 8'h00;
            arg1_q       <= 8'h00;
            argcnt_q     <= 1'b0;
            tmo_q        <= '0;
            upd_q        <= '0;
            hist_reset_q <= 1'b0;
            shadow_q     <= '0;
            reply_q      <= 8'h00;
            for (int k = 0; k < NREG; k++) begin
                cfg_q[k] <= CFG_INIT[8*k +: 8];
            end
        end else begin
            opcode_q     <= opcode_d;
            arg0_q       <= arg0_d;
            arg1_q       <= arg1_d;
            argcnt_q     <= argcnt_d;
            tmo_q        <= tmo_d;
            upd_q        <= upd_d;
            hist_reset_q <= hist_reset_d;
            shadow_q     <= shadow_d;
            reply_q      <= reply_d;
            for (int k = 0; k < NREG; k++) begin
                cfg_q[k] <= cfg_d[k];
            end
        end
    end

    // Reply buffer: the histogram shadow, or a single byte in position 0.
    always_comb begin
        w_buf = '0;
        if (opcode_q == OP_HIST) begin
            w_buf = shadow_q;
        end else begin
            w_buf[7:0] = reply_q;
        end
    end

    byte_tx_seq #(
        .NBYTES (c_NBYTES),
        .IDXW   (c_IDXW)
    ) u_tx_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (w_start),
        .len_i      (w_len),
        .buf_i      (w_buf),
        .tx_busy_i  (tx_busy),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .done_o     (w_done)
    );

    for (genvar k = 0; k < NREG; k++) begin : g_cfg
        assign cfg[8*k +: 8] = cfg_q[k];
    end

    assign cfg_update = upd_q;
    assign hist_reset = hist_reset_q;
    assign busy       = (state_q != ENG_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_cmd_engine
// Description : Self-checking bench for serial_cmd_engine with a byte-level
//               reference model of the command set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_cmd_engine;

    localparam int                NREG     = 16;
    localparam int                NBINS    = 34;
    localparam int                BIN_W    = 32;
    localparam int                TIMEOUT  = 100;
    localparam int                NBYTES   = NBINS * BIN_W / 8;
    localparam logic [7:0]        VERSION  = 8'd24;
    localparam logic [NREG*8-1:0] CFG_INIT = 128'h1F1E1D1C1B1A191817161514130F1110;

    logic                   clk;
    logic                   rst_n;
    logic                   rx_ready;
    logic [7:0]             rx_data;
    logic                   tx_busy;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic [NREG*8-1:0]      cfg;
    logic [NREG-1:0]        cfg_update;
    logic [NBINS*BIN_W-1:0] hist_data;
    logic                   hist_reset;
    logic                   busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] cfg_m [NREG];
    logic [7:0] exp_q [$];
    logic [7:0] act_q [$];
    logic [NREG-1:0] upd_seen;
    int         hr_cnt;
    int         busy_cnt;
    int         busy_hold;

    serial_cmd_engine #(
        .VERSION  (VERSION),
        .NREG     (NREG),
        .CFG_INIT (CFG_INIT),
        .NBINS    (NBINS),
        .BIN_W    (BIN_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .cfg        (cfg),
        .cfg_update (cfg_update),
        .hist_data  (hist_data),
        .hist_reset (hist_reset),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART transmitter model plus observation of replies and pulses.
    always @(negedge clk) begin
        if (tx_start) begin
            act_q.push_back(tx_data);
            busy_cnt = busy_hold;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        tx_busy = (busy_cnt != 0);
        upd_seen = upd_seen | cfg_update;
        if (hist_reset) hr_cnt = hr_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int cmd_nargs(input logic [7:0] op);
        if (op == 8'h01 || op == 8'h03) return 2;
        if (op == 8'h02) return 1;
        return 0;
    endfunction

    function automatic logic [NREG*8-1:0] model_flat();
        logic [NREG*8-1:0] f;
        for (int k = 0; k < NREG; k++) f[8*k +: 8] = cfg_m[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) cfg_m[k] = CFG_INIT[8*k +: 8];
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [7:0] a0,
                             input logic [7:0] a1, output logic [NREG-1:0] m);
        int idx;
        idx = int'(a0);
        m = '0;
        case (op)
            8'h00: exp_q.push_back(VERSION);
            8'h01: if (idx < NREG) begin cfg_m[idx] = a1; m[idx] = 1'b1; end
            8'h02: exp_q.push_back((idx < NREG) ? cfg_m[idx] : 8'h00);
            8'h03: if (idx < NREG) begin
                       cfg_m[idx][a1[2:0]] = ~cfg_m[idx][a1[2:0]];
                       m[idx] = 1'b1;
                   end
            8'h0A: for (int i = 0; i < NBYTES; i++) exp_q.push_back(hist_data[8*i +: 8]);
            default: ;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_obs();
        act_q.delete();
        exp_q.delete();
        upd_seen = '0;
        hr_cnt   = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a0, input logic [7:0] a1);
        int n;
        n = cmd_nargs(op);
        send_byte(op);
        if (n >= 1) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(a0);
        end
        if (n >= 2) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(a1);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
        hist_data = '0; busy_hold = 3; busy_cnt = 0; tx_busy = 1'b0;
        model_reset();
        clear_obs();
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cfg !== CFG_INIT) begin errors++; $display("FAIL reset_cfg: got %h want %h", cfg, CFG_INIT); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (cfg_update !== '0) begin errors++; $display("FAIL reset_cfg_update: got %h want 0", cfg_update); end
        checks++; if (hist_reset !== 1'b0) begin errors++; $display("FAIL reset_hist_reset: got %b want 0", hist_reset); end
    endtask

    task automatic test_version();
        bit ok;
        logic [NREG-1:0] m;
        clear_obs();
        model_cmd(8'h00, 8'h00, 8'h00, m);
        send_cmd(8'h00, 8'h00, 8'h00);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL version_idle: busy stuck high, want low"); end
        checks++; if (act_q.size() != 1) begin errors++; $display("FAIL version_count: got %0d bytes want 1", act_q.size()); end
        checks++; if (act_q[0] !== 8'h18) begin errors++; $display("FAIL version_byte: got %h want 18", act_q[0]); end
        checks++; if (cfg !== CFG_INIT) begin errors++; $display("FAIL version_cfg: got %h want %h", cfg, CFG_INIT); end
    endtask

    task automatic test_write_read();
        bit ok;
        logic [NREG-1:0] m;
        clear_obs();
        model_cmd(8'h01, 8'h05, 8'hA5, m);
        send_cmd(8'h01, 8'h05, 8'hA5);
        // now in cycle N+1 (EXEC)
        checks++; if (cfg_update !== '0) begin errors++; $display("FAIL write_upd_early: got %h want 0000 at N+1", cfg_update); end
        @(negedge clk);
        checks++; if (cfg_update !== 16'h0020) begin errors++; $display("FAIL write_upd_pulse: got %h want 0020 at N+2", cfg_update); end
        checks++; if (cfg[47:40] !== 8'hA5) begin errors++; $display("FAIL write_cfg5: got %h want a5", cfg[47:40]); end
        @(negedge clk);
        checks++; if (cfg_update !== '0) begin errors++; $display("FAIL write_upd_len: got %h want 0000 at N+3", cfg_update); end
        wait_idle(200, ok);
        checks++; if (cfg !== model_flat()) begin errors++; $display("FAIL write_cfg: got %h want %h", cfg, model_flat()); end

        clear_obs();
        model_cmd(8'h02, 8'h05, 8'h00, m);
        send_cmd(8'h02, 8'h05, 8'h00);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL read_early_start: got %b want 0 at N+1", tx_start); end
        wait_idle(200, ok);
        checks++; if (!ok || act_q.size() != 1 || act_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL read_back: got %0d bytes first %h want 1 byte %h", act_q.size(), act_q[0], exp_q[0]);
        end
    endtask

    task automatic test_toggle_oob();
        bit ok;
        logic [NREG-1:0] m;
        clear_obs();
        model_cmd(8'h03, 8'h02, 8'h0B, m);
        send_cmd(8'h03, 8'h02, 8'h0B);
        wait_idle(200, ok);
        checks++; if (cfg[23:16] !== 8'h07) begin errors++; $display("FAIL toggle_cfg2: got %h want 07", cfg[23:16]); end
        checks++; if (upd_seen !== 16'h0004) begin errors++; $display("FAIL toggle_upd: got %h want 0004", upd_seen); end

        clear_obs();
        model_cmd(8'h01, 8'h20, 8'h55, m);
        send_cmd(8'h01, 8'h20, 8'h55);
        wait_idle(200, ok);
        checks++; if (cfg !== model_flat()) begin errors++; $display("FAIL oob_write_cfg: got %h want %h", cfg, model_flat()); end
        checks++; if (upd_seen !== '0) begin errors++; $display("FAIL oob_write_upd: got %h want 0000", upd_seen); end

        clear_obs();
        send_cmd(8'h02, 8'h20, 8'h00);
        wait_idle(200, ok);
        checks++; if (act_q.size() != 1 || act_q[0] !== 8'h00) begin
            errors++; $display("FAIL oob_read: got %0d bytes first %h want 1 byte 00", act_q.size(), act_q[0]);
        end
    endtask

    task automatic test_hist();
        bit ok;
        int mism;
        logic [NREG-1:0] m;
        clear_obs();
        busy_hold = 3;
        for (int b = 0; b < NBINS; b++) hist_data[BIN_W*b +: BIN_W] = $urandom;
        hist_data[31:0] = 32'h04030201;
        hist_data[BIN_W*33 +: 32] = 32'hDEADBEEF;
        model_cmd(8'h0A, 8'h00, 8'h00, m);
        send_byte(8'h0A);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            // live histogram keeps moving after the snapshot
            if (hr_cnt > 0) hist_data[BIN_W*$urandom_range(0, NBINS-1) +: BIN_W] = $urandom;
            // a version request arriving mid-dump must be dropped
            rx_ready = (i == 20);
            rx_data  = 8'h00;
            if (!busy) begin ok = 1'b1; break; end
        end
        rx_ready = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL hist_idle: dump did not finish within budget"); end
        checks++; if (act_q.size() != NBYTES) begin errors++; $display("FAIL hist_count: got %0d bytes want %0d", act_q.size(), NBYTES); end
        checks++; if ({act_q[3], act_q[2], act_q[1], act_q[0]} !== 32'h04030201) begin
            errors++; $display("FAIL hist_first: got %h %h %h %h want 01 02 03 04", act_q[0], act_q[1], act_q[2], act_q[3]);
        end
        checks++; if ({act_q[NBYTES-1], act_q[NBYTES-2], act_q[NBYTES-3], act_q[NBYTES-4]} !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hist_last: got %h %h %h %h want ef be ad de",
                act_q[NBYTES-4], act_q[NBYTES-3], act_q[NBYTES-2], act_q[NBYTES-1]);
        end
        mism = 0;
        for (int i = 0; i < NBYTES; i++) if (act_q[i] !== exp_q[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL hist_bytes: got %0d mismatching bytes want 0", mism); end
        checks++; if (hr_cnt != 1) begin errors++; $display("FAIL hist_reset_count: got %0d pulses want 1", hr_cnt); end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [NREG-1:0] m;
        clear_obs();
        send_byte(8'h01);
        send_byte(8'h03);
        repeat (TIMEOUT - 10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early: busy got %b want 1", busy); end
        wait_idle(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_abort: busy still high after timeout"); end
        checks++; if (cfg !== model_flat() || upd_seen !== '0) begin
            errors++; $display("FAIL timeout_effect: cfg %h upd %h want cfg %h upd 0000", cfg, upd_seen, model_flat());
        end
        clear_obs();
        model_cmd(8'h00, 8'h00, 8'h00, m);
        send_cmd(8'h00, 8'h00, 8'h00);
        wait_idle(200, ok);
        checks++; if (act_q.size() != 1 || act_q[0] !== 8'h18) begin
            errors++; $display("FAIL timeout_recover: got %0d bytes first %h want 1 byte 18", act_q.size(), act_q[0]);
        end
    endtask

    task automatic test_random();
        bit ok;
        int mism;
        logic [7:0] op, a0, a1;
        logic [NREG-1:0] m;
        for (int it = 0; it < 40; it++) begin
            clear_obs();
            busy_hold = $urandom_range(1, 3);
            case ($urandom_range(0, 4))
                0: op = 8'h00;
                1: op = 8'h01;
                2: op = 8'h02;
                3: op = 8'h03;
                default: begin
                    op = 8'($urandom_range(4, 255));
                    if (op == 8'h0A) op = 8'h0B;
                end
            endcase
            a0 = 8'($urandom_range(0, 19));
            a1 = 8'($urandom);
            model_cmd(op, a0, a1, m);
            send_cmd(op, a0, a1);
            wait_idle(200, ok);
            mism = (act_q.size() != exp_q.size()) ? 1 : 0;
            if (mism == 0) for (int i = 0; i < exp_q.size(); i++) if (act_q[i] !== exp_q[i]) mism++;
            checks++; if (!ok || mism != 0) begin
                errors++; $display("FAIL rand_reply: op %h a0 %h got %0d bytes (%0d bad) want %0d", op, a0, act_q.size(), mism, exp_q.size());
            end
            checks++; if (upd_seen !== m) begin errors++; $display("FAIL rand_upd: op %h a0 %h got %h want %h", op, a0, upd_seen, m); end
            checks++; if (cfg !== model_flat()) begin errors++; $display("FAIL rand_cfg: op %h got %h want %h", op, cfg, model_flat()); end
        end
        busy_hold = 3;
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        int n0;
        logic [NREG-1:0] m;
        clear_obs();
        for (int b = 0; b < NBINS; b++) hist_data[BIN_W*b +: BIN_W] = $urandom;
        send_byte(8'h0A);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_start && act_q.size() >= 49) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_dump_reach: byte 50 not reached, got %0d bytes", act_q.size()); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_dump_async: tx_start %b busy %b want 0 0", tx_start, busy);
        end
        n0 = act_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        checks++; if (act_q.size() != n0) begin errors++; $display("FAIL rst_dump_abandon: got %0d extra bytes want 0", act_q.size() - n0); end
        checks++; if (cfg !== CFG_INIT) begin errors++; $display("FAIL rst_dump_cfg: got %h want %h", cfg, CFG_INIT); end
        clear_obs();
        model_cmd(8'h00, 8'h00, 8'h00, m);
        send_cmd(8'h00, 8'h00, 8'h00);
        wait_idle(200, ok);
        checks++; if (act_q.size() != 1 || act_q[0] !== 8'h18) begin
            errors++; $display("FAIL rst_dump_version: got %0d bytes first %h want 1 byte 18", act_q.size(), act_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_version();
        test_write_read();
        test_toggle_oob();
        test_hist();
        test_timeout();
        test_random();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_cmd_engine.md
# serial_cmd_engine

Parametrised UART command engine: the next-generation host-command block of the trigger board. It decodes opcode/argument bytes from the UART receiver into a generic bank of NREG 8-bit configuration registers, supports read-back, per-bit toggles and a snapshot/dump of an arbitrary-width histogram, and aborts stalled commands on a timeout. It sits between the UART rx/tx pair and the trigger, PLL and histogram logic, replacing fixed per-setting registers with indexed ones.

## Interface
- VERSION, 8'd24: firmware version byte returned by opcode 0x00.
- NREG, 16: number of 8-bit config registers (1..256).
- CFG_INIT, 0: NREG*8-bit reset image; register k = CFG_INIT[8k+7:8k].
- NBINS, 34: histogram bins.
- BIN_W, 32: bits per bin; multiple of 8.
- TIMEOUT, 1000000: idle clk cycles allowed between argument bytes.
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_ready  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle send strobe.
- tx_data  out  8  byte to send; stable while tx_start is high.
- cfg  out  NREG*8  flattened config registers.
- cfg_update  out  NREG  one-cycle pulse on bit k when register k is written or toggled.
- hist_data  in  NBINS*BIN_W  live histogram, bin 0 in the LSBs.
- hist_reset  out  1  one-cycle pulse that clears the histogram.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Opcodes (first byte) and argument counts:
  - 0x00 (0 args): send VERSION.
  - 0x01 addr data: cfg[addr] = data; pulse cfg_update[addr].
  - 0x02 addr: send cfg[addr]; send 0x00 if addr >= NREG.
  - 0x03 addr bit: invert cfg[addr][bit[2:0]]; pulse cfg_update[addr]; bit[7:3] ignored.
  - 0x0A (0 args): snapshot hist_data into a shadow register and pulse hist_reset in the same cycle. Then send NBINS*BIN_W/8 bytes: bin 0 first, LSB byte first.
  - Any other opcode: ignored, return to IDLE.
- Writes and toggles with addr >= NREG have no effect and no pulse.
- FSM:
  - IDLE: on rx_ready, capture the opcode. Go to ARGS if the opcode needs arguments, else EXEC.
  - ARGS: store each byte into arg[0..1]. After the last byte go to EXEC. If the timeout counter reaches TIMEOUT, go to IDLE with no effect.
  - EXEC: perform the action. Go to TX_SEND if there is a reply, else IDLE.
  - TX_SEND: wait for !tx_busy, then assert tx_start with tx_data; go to TX_GAP.
  - TX_GAP: tx_start low for one cycle. Increment the byte index; go to TX_SEND, or IDLE after the last byte.
- rx_ready outside IDLE/ARGS (EXEC, TX_*) is dropped, not queued.
- The timeout counter clears on entering ARGS and on every rx_ready. It saturates and is not used outside ARGS.
- The dump byte index is $clog2(NBINS*BIN_W/8+1) bits wide; there is no wrap-around.

## Timing
- Reset values: cfg = CFG_INIT; tx_start, tx_data, cfg_update, hist_reset, busy = 0; state = IDLE; shadow and args = 0.
- Let N be the cycle in which rx_ready delivers the last byte of a command:
  - EXEC at N+1.
  - cfg change and cfg_update/hist_reset pulse registered at N+2.
  - First tx_start no earlier than N+2.
- Consecutive tx_start pulses are at least 2 cycles apart. The UART must raise tx_busy within one cycle of tx_start.
- Shadow contents equal hist_data sampled in EXEC. Histogram increments in the same cycle as hist_reset are lost (accepted).
- busy rises the cycle after the opcode's rx_ready and falls on return to IDLE.
- Reset mid-command or mid-dump: immediate return to reset values. No further tx_start; the partial reply is abandoned.

## Structure
- Package serial_cmd_pkg:
  - opcode localparams (OP_VERSION, OP_WRITE, OP_READ, OP_TOGGLE, OP_HIST);
  - state enum;
  - function nargs(opcode) returning the argument count.
- Sub-module byte_tx_seq owns TX_SEND/TX_GAP, the byte index and the tx_start/tx_busy handshake. It serialises a reply buffer of up to NBINS*BIN_W/8 bytes; start/done strobes connect it to the engine.

## Test plan
- Reset, then 0x00 → exactly one tx_start with tx_data 0x18; busy returns low; cfg == CFG_INIT.
- 0x01 0x05 0xA5, then 0x02 0x05:
  - cfg[47:40] = 0xA5;
  - cfg_update = 16'h0020 for one cycle, at N+2;
  - read-back sends 0xA5.
- 0x03 0x02 0x0B on cfg[2] = 0x0F → cfg[2] = 0x07. 0x01 0x20 0x55 with NREG=16 → no cfg change, no pulse. 0x02 0x20 → sends 0x00.
- hist_data bin0 = 0x04030201, bin33 = 0xDEADBEEF, tx_busy held high 3 cycles after each tx_start:
  - 136 bytes sent, starting 01 02 03 04, ending EF BE AD DE;
  - one hist_reset pulse;
  - hist_data changes during the dump do not alter the bytes sent.
- 0x01 0x03, then silence for TIMEOUT cycles (TIMEOUT=100 in the bench) → return to IDLE, cfg unchanged. A following 0x00 is handled normally.
- rst_n low during byte 50 of a dump → tx_start low at once. After release, cfg == CFG_INIT and 0x00 works.
